// File: rtl/free_reg_list_pkg.sv
// Shared defaults for the rename-stage register free lists and the pointer/address types
// that checkpoint logic uses to capture and restore free-list read pointers.
package free_reg_list_pkg;

  localparam int unsigned NUM_D_REG_DEF = 32;
  localparam int unsigned NUM_L_D_DEF   = 16;
  localparam int unsigned NUM_S_REG_DEF = 16;
  localparam int unsigned NUM_L_S_DEF   = 8;

  localparam int unsigned D_CAP_DEF = NUM_D_REG_DEF - NUM_L_D_DEF;
  localparam int unsigned S_CAP_DEF = NUM_S_REG_DEF - NUM_L_S_DEF;

  // Pointer width: index bits plus one lap bit.
  function automatic int unsigned ptr_w(input int unsigned cap);
    return $clog2(cap) + 1;
  endfunction

  typedef logic [$clog2(NUM_D_REG_DEF)-1:0] d_addr_t;
  typedef logic [$clog2(NUM_S_REG_DEF)-1:0] s_addr_t;
  typedef logic [ptr_w(D_CAP_DEF)-1:0]      d_ptr_t;
  typedef logic [ptr_w(S_CAP_DEF)-1:0]      s_ptr_t;

endpackage

// File: rtl/free_list_fifo.sv
// Circular free list for one register class; head is the allocation side, tail the
// commit-side release. Pointers carry a lap bit so full and empty are distinguishable.
module free_list_fifo
  import free_reg_list_pkg::*;
#(
  parameter int unsigned CAP    = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BASE   = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   alloc_i,
  input  logic                   ret_i,
  input  logic [ADDR_W-1:0]      ret_addr_i,
  input  logic                   restore_i,
  input  logic [ptr_w(CAP)-1:0]  restore_head_i,
  output logic [ADDR_W-1:0]      head_addr_o,
  output logic                   empty_o,
  output logic [ptr_w(CAP)-1:0]  head_o
);

  localparam int unsigned PW = ptr_w(CAP);
  localparam int unsigned IW = PW - 1;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     count;
  logic              full;
  logic              ret_ok;
  logic [ADDR_W-1:0] entries_q [CAP];

  assign count       = tail_q - head_q;
  assign empty_o     = (count == '0);
  assign full        = (count == PW'(CAP));
  assign ret_ok      = ret_i && !full;
  assign head_addr_o = entries_q[head_q[IW-1:0]];
  assign head_o      = head_q;

  // Restore overrides alloc; entries skipped by the restore are still intact in storage.
  always_comb begin
    head_d = head_q;
    if (restore_i) begin
      head_d = restore_head_i;
    end else if (alloc_i && !empty_o) begin
      head_d = head_q + PW'(1);
    end
  end

  always_comb begin
    tail_d = tail_q;
    if (ret_ok) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q <= '0;
      tail_q <= PW'(CAP);
      for (int unsigned i = 0; i < CAP; i++) begin
        entries_q[i] <= ADDR_W'(BASE + i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (ret_ok) begin
        entries_q[tail_q[IW-1:0]] <= ret_addr_i;
      end
    end
  end

  // A release into a full list means the reorder buffer returned a register twice.
  no_return_when_full_a : assert property (@(posedge clk) disable iff (!n_rst) !(ret_i && full));

endmodule

// File: rtl/free_reg_list.sv
// Physical register free lists for the rename stage: one for data registers, one for
// status registers, each an independent circular queue with checkpointable read pointer.
module free_reg_list
  import free_reg_list_pkg::*;
#(
  parameter int unsigned NUM_D_REG = NUM_D_REG_DEF,
  parameter int unsigned NUM_L_D   = NUM_L_D_DEF,
  parameter int unsigned NUM_S_REG = NUM_S_REG_DEF,
  parameter int unsigned NUM_L_S   = NUM_L_S_DEF
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 alloc_r,
  input  logic                                 alloc_s,
  output logic [$clog2(NUM_D_REG)-1:0]         rw_addr,
  output logic [$clog2(NUM_S_REG)-1:0]         rs_addr,
  output logic                                 r_empty,
  output logic                                 s_empty,
  input  logic                                 return_r,
  input  logic [$clog2(NUM_D_REG)-1:0]         r_addr,
  input  logic                                 return_s,
  input  logic [$clog2(NUM_S_REG)-1:0]         s_addr,
  output logic [$clog2(NUM_D_REG-NUM_L_D):0]   r_head,
  output logic [$clog2(NUM_S_REG-NUM_L_S):0]   s_head,
  input  logic                                 restore,
  input  logic [$clog2(NUM_D_REG-NUM_L_D):0]   restore_r_head,
  input  logic [$clog2(NUM_S_REG-NUM_L_S):0]   restore_s_head
);

  localparam int unsigned D_CAP = NUM_D_REG - NUM_L_D;
  localparam int unsigned S_CAP = NUM_S_REG - NUM_L_S;

  free_list_fifo #(
    .CAP    (D_CAP),
    .ADDR_W ($clog2(NUM_D_REG)),
    .BASE   (NUM_L_D)
  ) u_data_list (
    .clk            (clk),
    .n_rst          (n_rst),
    .alloc_i        (alloc_r),
    .ret_i          (return_r),
    .ret_addr_i     (r_addr),
    .restore_i      (restore),
    .restore_head_i (restore_r_head),
    .head_addr_o    (rw_addr),
    .empty_o        (r_empty),
    .head_o         (r_head)
  );

  free_list_fifo #(
    .CAP    (S_CAP),
    .ADDR_W ($clog2(NUM_S_REG)),
    .BASE   (NUM_L_S)
  ) u_status_list (
    .clk            (clk),
    .n_rst          (n_rst),
    .alloc_i        (alloc_s),
    .ret_i          (return_s),
    .ret_addr_i     (s_addr),
    .restore_i      (restore),
    .restore_head_i (restore_s_head),
    .head_addr_o    (rs_addr),
    .empty_o        (s_empty),
    .head_o         (s_head)
  );

endmodule

// File: tb/tb_free_reg_list.sv
// Scoreboard bench for free_reg_list: stimulus pushes hand-computed expected outputs,
// a monitor pops and compares them against the DUT one cycle later.
module tb_free_reg_list;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       alloc_r = 1'b0, alloc_s = 1'b0;
  logic       return_r = 1'b0, return_s = 1'b0;
  logic [4:0] r_addr = '0;
  logic [3:0] s_addr = '0;
  logic       restore = 1'b0;
  logic [4:0] restore_r_head = '0;
  logic [3:0] restore_s_head = '0;
  logic [4:0] rw_addr;
  logic [3:0] rs_addr;
  logic       r_empty, s_empty;
  logic [4:0] r_head;
  logic [3:0] s_head;

  free_reg_list dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .alloc_r        (alloc_r),
    .alloc_s        (alloc_s),
    .rw_addr        (rw_addr),
    .rs_addr        (rs_addr),
    .r_empty        (r_empty),
    .s_empty        (s_empty),
    .return_r       (return_r),
    .r_addr         (r_addr),
    .return_s       (return_s),
    .s_addr         (s_addr),
    .r_head         (r_head),
    .s_head         (s_head),
    .restore        (restore),
    .restore_r_head (restore_r_head),
    .restore_s_head (restore_s_head)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] rw;
    logic       re;
    logic [4:0] rh;
    logic [3:0] rs;
    logic       se;
    logic [3:0] sh;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_checks = 0;
  int   n_fail = 0;
  event chk_ev;

  function automatic void cmp(string tag, string what, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, what, got, want);
    end
  endfunction

  // Head address is undefined while empty, so it is only compared when non-empty.
  function automatic void check(exp_t e);
    cmp(e.tag, "r_empty", int'(r_empty), int'(e.re));
    cmp(e.tag, "r_head", int'(r_head), int'(e.rh));
    if (!e.re) cmp(e.tag, "rw_addr", int'(rw_addr), int'(e.rw));
    cmp(e.tag, "s_empty", int'(s_empty), int'(e.se));
    cmp(e.tag, "s_head", int'(s_head), int'(e.sh));
    if (!e.se) cmp(e.tag, "rs_addr", int'(rs_addr), int'(e.rs));
  endfunction

  always @(negedge clk) if (q.size() > 0) check(q.pop_front());
  always @(chk_ev) if (q.size() > 0) check(q.pop_front());

  task automatic go();
    @(negedge clk);
    #1;
    alloc_r = 1'b0; alloc_s = 1'b0; return_r = 1'b0; return_s = 1'b0;
    restore = 1'b0; r_addr = '0; s_addr = '0;
  endtask

  task automatic push(string tag);
    m.tag = tag;
    q.push_back(m);
  endtask

  task automatic set_reset_model();
    m.rw = 5'd16; m.re = 1'b0; m.rh = 5'd0;
    m.rs = 4'd8;  m.se = 1'b0; m.sh = 4'd0;
  endtask

  task automatic do_reset();
    go(); n_rst = 1'b0;
    go(); n_rst = 1'b1;
    set_reset_model();
    push("reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_reset_model();
    do_reset();

    // Drain the data list; status list must stay untouched.
    for (int i = 0; i < 16; i++) begin
      go(); alloc_r = 1'b1;
      m.rh = 5'(i + 1); m.rw = 5'(17 + i); m.re = (i == 15);
      push("drain_r");
    end
    go(); alloc_r = 1'b1;
    push("alloc_when_empty");

    // Return while empty with a same-cycle alloc that must be ignored.
    go(); alloc_r = 1'b1; return_r = 1'b1; r_addr = 5'd5;
    m.re = 1'b0; m.rw = 5'd5;
    push("return_from_empty");
    go(); alloc_r = 1'b1;
    m.rh = 5'd17; m.re = 1'b1;
    push("alloc_returned");

    // Checkpoint restore.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      go(); alloc_r = 1'b1;
      m.rh = 5'(i + 1); m.rw = 5'(17 + i);
      push("alloc3");
    end
    go(); restore = 1'b1; restore_r_head = 5'd0; restore_s_head = 4'd0; alloc_r = 1'b1;
    m.rh = 5'd0; m.rw = 5'd16;
    push("restore_r");

    // Walk head to 15, then alloc+return together across the wrap.
    for (int i = 0; i < 15; i++) begin
      go(); alloc_r = 1'b1;
      m.rh = 5'(i + 1); m.rw = 5'(17 + i);
      push("walk_r");
    end
    go(); alloc_r = 1'b1; return_r = 1'b1; r_addr = 5'd9;
    m.rh = 5'd16; m.rw = 5'd9;
    push("wrap_alloc_return");
    go(); alloc_r = 1'b1;
    m.rh = 5'd17; m.re = 1'b1;
    push("wrap_count_one");

    // Status: restore + alloc + return in one cycle; data head restored onto itself.
    for (int i = 0; i < 2; i++) begin
      go(); alloc_s = 1'b1;
      m.sh = 4'(i + 1); m.rs = 4'(9 + i);
      push("alloc_s");
    end
    go(); restore = 1'b1; restore_r_head = 5'd17; restore_s_head = 4'd1;
    alloc_s = 1'b1; return_s = 1'b1; s_addr = 4'd3;
    m.sh = 4'd1; m.rs = 4'd9;
    push("restore_s_combo");
    for (int i = 0; i < 7; i++) begin
      go(); alloc_s = 1'b1;
      m.sh = 4'(2 + i); m.rs = (i < 6) ? 4'(10 + i) : 4'd3;
      push("walk_s");
    end
    go(); alloc_s = 1'b1;
    m.sh = 4'd9; m.se = 1'b1;
    push("s_empty_after");

    // Asynchronous reset in the middle of an allocation burst.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      go(); alloc_r = 1'b1; alloc_s = 1'b1;
      m.rh = 5'(i + 1); m.rw = 5'(17 + i); m.sh = 4'(i + 1); m.rs = 4'(9 + i);
      push("burst");
    end
    go(); alloc_r = 1'b1; alloc_s = 1'b1; n_rst = 1'b0;
    #1;
    set_reset_model();
    push("async_reset_now");
    -> chk_ev;
    go(); alloc_r = 1'b1;
    push("reset_held");
    go(); n_rst = 1'b1;
    push("reset_released");
    go();
    go();

    cmp("end", "queue_left", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/free_reg_list.md
FREE_REG_LIST -- requirements
Module: free_reg_list

Interface
REQ-001 SHALL have parameter NUM_D_REG, 32, physical data registers.
REQ-002 SHALL have parameter NUM_L_D, 16, logical data registers; D_CAP = NUM_D_REG-NUM_L_D, power of two.
REQ-003 SHALL have parameter NUM_S_REG, 16, physical status registers.
REQ-004 SHALL have parameter NUM_L_S, 8, logical status registers; S_CAP = NUM_S_REG-NUM_L_S, power of two.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port alloc_r / alloc_s  in  1 each  rename stage consumes a data / status register this cycle.
REQ-008 SHALL have port rw_addr  out  clog2(NUM_D_REG)  next free data register (head entry).
REQ-009 SHALL have port rs_addr  out  clog2(NUM_S_REG)  next free status register (head entry).
REQ-010 SHALL have port r_empty / s_empty  out  1 each  no free register of that class.
REQ-011 SHALL have port return_r, r_addr, return_s, s_addr  in  1/clog2(NUM_D_REG)/1/clog2(NUM_S_REG)  commit-side register release from reorder buffer.
REQ-012 SHALL have port r_head / s_head  out  clog2(D_CAP)+1 / clog2(S_CAP)+1  current read pointers incl. lap bit, captured by branch checkpoints.
REQ-013 SHALL have port restore  in  1  misprediction recovery strobe.
REQ-014 SHALL have port restore_r_head / restore_s_head  in  widths as REQ-012  checkpointed read pointers.

Function
REQ-015 Each class SHALL be a circular queue of CAP entries with head/tail pointers carrying one lap bit; count = tail-head modulo 2*CAP.
REQ-016 rw_addr/rs_addr SHALL be combinational reads of entry[head] (zero-latency lookahead); value undefined when empty.
REQ-017 empty SHALL equal (count==0), combinational from registered pointers.
REQ-018 alloc with empty=0 SHALL advance head by 1 (wrap at CAP) next edge; alloc with empty=1 SHALL be ignored.
REQ-019 return SHALL write addr into entry[tail] and advance tail next edge; returned register allocatable from the following cycle (no same-cycle bypass).
REQ-020 return when count==CAP SHALL be dropped and flagged by a simulation assertion.
REQ-021 restore SHALL load head from restore_*_head next edge; entries between restored and current head become free again without rewrite.
REQ-022 restore and alloc in same cycle: restore wins, alloc ignored.
REQ-023 restore and return in same cycle: both apply (head restored, tail advances).
REQ-024 alloc and return in same cycle on non-empty queue: both apply, count unchanged.
REQ-025 Data and status classes SHALL operate fully independently.

Reset
REQ-026 On n_rst low (async): head=0, tail=CAP with lap bit set (full), entry[i]=NUM_L+i for each class.
REQ-027 Outputs after reset: empty=0, rw_addr=NUM_L_D, rs_addr=NUM_L_S, r_head=s_head=0.
REQ-028 Reset asserted mid-operation SHALL discard all allocations/returns in flight and reinstate REQ-026 state.

Structure
REQ-029 NUM_D_REG, NUM_S_REG, NUM_L_D, NUM_L_S defaults and pointer-width typedefs SHALL live in the shared nand_cpu package/header.
REQ-030 One sub-module free_list_fifo (parameters CAP, ADDR_W, BASE) SHALL implement one class; instantiated twice.
REQ-031 Ports REQ-007..011 SHALL map onto free_reg_list_ifc and reorder_buffer_ifc modports at integration.

Verification
REQ-032 Reset, then 16 alloc_r cycles -> rw_addr 16,17..31, r_empty=1 after 16th; 17th alloc ignored.
REQ-033 From empty, return_r r_addr=5 -> r_empty=0 next cycle, rw_addr=5; same-cycle alloc_r while empty ignored.
REQ-034 Save r_head=0, alloc 3 (16,17,18), restore with restore_r_head=0 -> rw_addr=16, count=16.
REQ-035 Head at 15, alloc_r and return_r addr=9 same cycle -> head wraps to 0 lap 1, count unchanged, tail entry=9.
REQ-036 restore + alloc_s + return_s addr=3 same cycle -> s_head=restore_s_head, alloc ignored, tail advances with 3.
REQ-037 Assert n_rst low mid-burst of allocs -> immediate full state, rw_addr=16, rs_addr=8.
